systolic_seq: RTL and testbench
===============================

# systolic_seq

Sequencer for the DIM×DIM systolic matrix-multiply array. It loads DIM rows of A and B into the per-row/per-column input FIFOs. It then drives the skewed per-FIFO shift enables so that operand i enters the array i cycles after operand 0, gates the MAC enable and clear, and reports completion. It sits between the host/memory row source and the FIFO banks and MAC grid.

## Interface
- DIM, 8, array dimension; also the number of A FIFOs, the number of B FIFOs and the FIFO depth.
- EXEC_LEN, 3*DIM-2, execute-phase length in cycles (localparam, not overridable).

- clk  in  1  clock
- rst_n  in  1  reset: asynchronous, active-low
- start  in  1  begin one matmul; sampled only in IDLE
- row_vld  in  1  row source presents row row_idx of both A and B this cycle
- row_rdy  out  1  sequencer accepts a row (high throughout LOAD)
- row_idx  out  $clog2(DIM)  index of the next row to accept
- wr_a  out  DIM  one-hot write enable to A FIFO banks; bit row_idx = row_vld & row_rdy
- wr_b  out  DIM  same as wr_a, for the B FIFO banks
- en  out  DIM  shift enable; bit i is shared by A FIFO i and B FIFO i
- mac_clr  out  1  clear all MAC accumulators
- mac_en  out  1  MAC grid accumulate enable
- busy  out  1  matmul in progress
- done  out  1  one-cycle completion pulse

## Operation
- States: IDLE, LOAD, EXEC, DONE. The state register, a row counter (rcnt) and an exec counter (cnt, $clog2(EXEC_LEN) bits) are the only flops.
- IDLE:
  - start=1 → LOAD, with rcnt=0.
  - start=0 → stay.
- LOAD:
  - row_rdy=1 and row_idx=rcnt.
  - row_vld=1 → wr_a/wr_b pulse bit rcnt and rcnt increments.
  - A row accepted when rcnt=DIM-1 → EXEC, with cnt=0. rcnt does not wrap.
  - row_vld=0 → hold. There is no timeout.
- EXEC:
  - mac_en=1.
  - en[i] = (cnt ≥ i) && (cnt < i+DIM), i.e. FIFO i shifts for DIM consecutive cycles starting at cnt=i.
  - cnt increments every cycle. cnt=EXEC_LEN-1 → DONE.
- DONE: done=1 for one cycle, then IDLE unconditionally.
- Output decode:
  - busy=1 in LOAD and EXEC.
  - mac_clr=1 in the first LOAD cycle only.
  - All outputs are Moore decodes of state/counters, except wr_a/wr_b, which are gated by row_vld.
- wr_a/wr_b are never asserted outside LOAD. en is all-zero outside EXEC.
- The sequencer never asserts wr and en to the same FIFO in the same cycle.

## Timing
- Reset values: state IDLE, rcnt=0, cnt=0. All outputs 0 (row_idx=0, wr_a=wr_b=en=0, mac_clr=mac_en=busy=done=row_rdy=0).
- start high in IDLE at cycle T:
  - LOAD at T+1; busy, row_rdy and mac_clr are 1 at T+1.
  - Minimum LOAD length is DIM cycles (row_vld held high).
- Last row accepted at cycle L:
  - EXEC spans L+1 … L+EXEC_LEN.
  - done=1 at L+EXEC_LEN+1.
  - IDLE at L+EXEC_LEN+2, where a new start is accepted.
- Minimum start-to-done latency: DIM+EXEC_LEN+1 cycles.
- start outside IDLE, including the DONE cycle, is ignored with no queuing.
- row_vld outside LOAD is ignored and produces no wr pulse.
- rst_n asserted mid-LOAD or mid-EXEC: all outputs go to 0 immediately (asynchronously). Partial FIFO contents are the FIFOs' own concern.

## Configuration
- SYSTOLIC_SEQ_ACCUM_EN defined:
  - Adds input port accum (1 bit), sampled with start in IDLE and registered.
  - If accum=1, mac_clr is suppressed for that matmul, so results accumulate onto prior MAC contents.
  - All other behaviour is unchanged.
- SYSTOLIC_SEQ_ACCUM_EN undefined: the accum port is absent and mac_clr always pulses in the first LOAD cycle.

## Structure
- Shared package systolic_pkg holds:
  - the state enum typedef (IDLE/LOAD/EXEC/DONE);
  - the EXEC_LEN and counter-width constant functions, used by any block that must know array fill/drain time.
- One sub-module, seq_skew_dec: a combinational cnt → en[DIM] window decoder, parameterized by DIM. It is reusable by an output-drain sequencer.

## Test plan (DIM=8, EXEC_LEN=22)
- Reset then idle 10 cycles, with start=0 and row_vld toggling → all outputs remain 0 and no wr pulses occur.
- start at T with row_vld held high → mac_clr only at T+1; wr_a/wr_b one-hot 0x01, 0x02, … 0x80 on T+1…T+8; done exactly at T+31.
- During EXEC, check en against the window rule every cycle:
  - cnt=0 → 0x01; cnt=7 → 0xFF; cnt=14 → 0x80; cnt=15…21 → 0x00;
  - each en bit high exactly 8 cycles.
- row_vld deasserted for 3 cycles after row 4 → row_idx holds at 5, no wr pulses occur, and done shifts 3 cycles later (T+34).
- start pulsed during EXEC and during DONE → ignored; a start the cycle after DONE (IDLE) begins a new LOAD.
- rst_n asserted at EXEC cnt=10 → outputs 0 immediately; after release, a clean matmul completes. With SYSTOLIC_SEQ_ACCUM_EN defined and accum=1, mac_clr stays 0 for the whole run.

Source files
------------

// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic array sequencers: the phase
// encoding and the fill/drain timing helpers derived from the array size.
package systolic_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      EXEC = 2'd2,
      DONE = 2'd3
   } state_t;

   // Cycles needed for operand 0 to enter and operand DIM-1 to drain out.
   function automatic int exec_len(input int dim);
      return 3 * dim - 2;
   endfunction

   // Width of a counter that walks the execute phase.
   function automatic int cnt_w(input int dim);
      return $clog2(exec_len(dim));
   endfunction

   // Width of a row index; never below one bit.
   function automatic int idx_w(input int dim);
      return (dim > 1) ? $clog2(dim) : 1;
   endfunction

endpackage

// File: rtl/systolic_seq_if.sv
// Row-source / FIFO-bank / MAC-grid signal bundle of the systolic sequencer.
// Optional feature macro: SYSTOLIC_SEQ_ACCUM_EN adds the accum input.
interface systolic_seq_if
   import systolic_pkg::*;
#(
   parameter int DIM = 8
);
   logic                    start;
   logic                    row_vld;
   logic                    row_rdy;
   logic [idx_w(DIM)-1:0]   row_idx;
   logic [DIM-1:0]          wr_a;
   logic [DIM-1:0]          wr_b;
   logic [DIM-1:0]          en;
   logic                    mac_clr;
   logic                    mac_en;
   logic                    busy;
   logic                    done;
`ifdef SYSTOLIC_SEQ_ACCUM_EN
   logic                    accum;

   modport master (
      input  start, row_vld, accum,
      output row_rdy, row_idx, wr_a, wr_b, en, mac_clr, mac_en, busy, done
   );

   modport slave (
      output start, row_vld, accum,
      input  row_rdy, row_idx, wr_a, wr_b, en, mac_clr, mac_en, busy, done
   );
`else
   modport master (
      input  start, row_vld,
      output row_rdy, row_idx, wr_a, wr_b, en, mac_clr, mac_en, busy, done
   );

   modport slave (
      output start, row_vld,
      input  row_rdy, row_idx, wr_a, wr_b, en, mac_clr, mac_en, busy, done
   );
`endif
endinterface

// File: rtl/systolic_seq_skew_dec.sv
// Skewed shift-enable window decoder: lane i is enabled for DIM consecutive
// counts starting at count i, so operand i trails operand 0 by i cycles.
module seq_skew_dec #(
   parameter int DIM = 8,
   parameter int CW  = 5
) (
   input  logic          act,
   input  logic [CW-1:0] cnt,
   output logic [DIM-1:0] en
);

   // Per-lane window compare against the shared counter.
   always_comb begin
      en = {DIM{1'b0}};
      for (int i = 0; i < DIM; i++) begin
         if (act && (cnt >= CW'(i)) && (cnt < CW'(i + DIM))) begin
            en[i] = 1'b1;
         end else begin
            en[i] = 1'b0;
         end
      end
   end

endmodule

// File: rtl/systolic_seq.sv
// Systolic matmul sequencer: loads DIM rows into the A/B FIFO banks, then
// drives the skewed shift enables and MAC enable, then pulses done.
// Optional feature macro: SYSTOLIC_SEQ_ACCUM_EN (accumulate onto prior
// MAC contents by suppressing the clear pulse).
module systolic_seq
   import systolic_pkg::*;
#(
   parameter int DIM = 8
) (
   input  logic            clk,
   input  logic            rst_n,
   systolic_seq_if.master  bus
);

   localparam int EXEC_LEN = exec_len(DIM);
   localparam int CW       = cnt_w(DIM);
   localparam int IW       = idx_w(DIM);

   localparam logic [1:0] S_IDLE = IDLE;
   localparam logic [1:0] S_LOAD = LOAD;
   localparam logic [1:0] S_EXEC = EXEC;
   localparam logic [1:0] S_DONE = DONE;

   logic [1:0]    state_r, nxt_state_s;
   logic [IW-1:0] rcnt_r, nxt_rcnt_s;
   logic [CW-1:0] cnt_r, nxt_cnt_s;
   logic          load_s, exec_s, clr_ok_s;
   logic [DIM-1:0] wr_s;

   assign load_s = (state_r == S_LOAD);
   assign exec_s = (state_r == S_EXEC);

   // Phase sequencing; in LOAD the exec counter doubles as a
   // "first cycle already passed" marker for the clear pulse.
   always_comb begin
      nxt_state_s = state_r;
      nxt_rcnt_s  = rcnt_r;
      nxt_cnt_s   = cnt_r;
      case (state_r)
         S_IDLE: begin
            if (bus.start) begin
               nxt_state_s = S_LOAD;
               nxt_rcnt_s  = {IW{1'b0}};
               nxt_cnt_s   = {CW{1'b0}};
            end else begin
               nxt_state_s = S_IDLE;
            end
         end
         S_LOAD: begin
            if (bus.row_vld) begin
               if (rcnt_r == IW'(DIM - 1)) begin
                  nxt_state_s = S_EXEC;
                  nxt_cnt_s   = {CW{1'b0}};
               end else begin
                  nxt_rcnt_s  = rcnt_r + IW'(1);
                  nxt_cnt_s   = CW'(1);
               end
            end else begin
               nxt_cnt_s = CW'(1);
            end
         end
         S_EXEC: begin
            if (cnt_r == CW'(EXEC_LEN - 1)) begin
               nxt_state_s = S_DONE;
               nxt_cnt_s   = {CW{1'b0}};
            end else begin
               nxt_cnt_s = cnt_r + CW'(1);
            end
         end
         S_DONE: begin
            nxt_state_s = S_IDLE;
         end
         default: begin
            nxt_state_s = S_IDLE;
            nxt_rcnt_s  = {IW{1'b0}};
            nxt_cnt_s   = {CW{1'b0}};
         end
      endcase
   end

   // State and counter registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= S_IDLE;
         rcnt_r  <= {IW{1'b0}};
         cnt_r   <= {CW{1'b0}};
      end else begin
         state_r <= nxt_state_s;
         rcnt_r  <= nxt_rcnt_s;
         cnt_r   <= nxt_cnt_s;
      end
   end

`ifdef SYSTOLIC_SEQ_ACCUM_EN
   logic accum_r;

   // Capture the accumulate request alongside an accepted start.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         accum_r <= 1'b0;
      end else if ((state_r == S_IDLE) && bus.start) begin
         accum_r <= bus.accum;
      end else begin
         accum_r <= accum_r;
      end
   end

   assign clr_ok_s = ~accum_r;
`else
   assign clr_ok_s = 1'b1;
`endif

   assign wr_s = (load_s && bus.row_vld) ? ({{(DIM-1){1'b0}}, 1'b1} << rcnt_r)
                                          : {DIM{1'b0}};

   // Moore output decode; only the FIFO write strobes follow row_vld.
   always_comb begin
      bus.row_rdy = load_s;
      bus.row_idx = load_s ? rcnt_r : {IW{1'b0}};
      bus.wr_a    = wr_s;
      bus.wr_b    = wr_s;
      bus.mac_clr = load_s && (cnt_r == {CW{1'b0}}) && clr_ok_s;
      bus.mac_en  = exec_s;
      bus.busy    = load_s | exec_s;
      bus.done    = (state_r == S_DONE);
   end

   seq_skew_dec #(
      .DIM (DIM),
      .CW  (CW)
   ) u_skew (
      .act (exec_s),
      .cnt (cnt_r),
      .en  (bus.en)
   );

endmodule

// File: tb/tb_systolic_seq.sv
// Self-checking bench for systolic_seq against a timestamp-based model:
// a matmul is described by the cycle its LOAD began and the cycle its last
// row was taken; every expected output follows from those two numbers.
module tb_systolic_seq;

   localparam int DIM      = 8;
   localparam int EXEC_LEN = 3 * DIM - 2;

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   systolic_seq_if #(.DIM(DIM)) bus ();

   systolic_seq #(.DIM(DIM)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int checks = 0;
   int errors = 0;
   int c      = 0;
   int cur    = 0;
   int t_load = -1;
   int t_last = -1;
   int rows   = 0;
   bit accum_m = 1'b0;
   int en_cnt [DIM];
   int last_done = -1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // 0 idle, 1 load, 2 exec, 3 done
   function automatic int phase(input int cc);
      if (t_load >= 0 && cc >= t_load && t_last < 0) return 1;
      if (t_last >= 0 && cc > t_last && cc <= t_last + EXEC_LEN) return 2;
      if (t_last >= 0 && cc == t_last + EXEC_LEN + 1) return 3;
      return 0;
   endfunction

   task automatic cycle(input bit rn, input bit st, input bit rv, input bit ac);
      int ph;
      int ec;
      logic [DIM-1:0] exp_en;
      logic [DIM-1:0] exp_wr;
      @(negedge clk);
      rst_n       = rn;
      bus.start   = st;
      bus.row_vld = rv;
`ifdef SYSTOLIC_SEQ_ACCUM_EN
      bus.accum   = ac;
`endif
      #1;
      cur = c;
      if (!rn) begin
         t_load = -1;
         t_last = -1;
         rows   = 0;
      end
      ph = phase(c);
      ec = c - t_last - 1;
      exp_en = '0;
      exp_wr = '0;
      for (int i = 0; i < DIM; i++) exp_en[i] = (ph == 2) && (ec >= i) && (ec < i + DIM);
      if (ph == 1 && rv) exp_wr[rows] = 1'b1;
      chk("row_rdy", 32'(bus.row_rdy), 32'(ph == 1));
      chk("row_idx", 32'(bus.row_idx), (ph == 1) ? rows : 0);
      chk("wr_a",    32'(bus.wr_a), 32'(exp_wr));
      chk("wr_b",    32'(bus.wr_b), 32'(exp_wr));
      chk("en",      32'(bus.en),   32'(exp_en));
      chk("mac_clr", 32'(bus.mac_clr), 32'(ph == 1 && c == t_load && !accum_m));
      chk("mac_en",  32'(bus.mac_en), 32'(ph == 2));
      chk("busy",    32'(bus.busy),   32'(ph == 1 || ph == 2));
      chk("done",    32'(bus.done),   32'(ph == 3));
      chk("wr_en_overlap", 32'(bus.wr_a & bus.en), 32'd0);
      if (ph == 2) begin
         for (int i = 0; i < DIM; i++) en_cnt[i] += int'(bus.en[i]);
      end
      if (ph == 3) begin
         for (int i = 0; i < DIM; i++) chk("en_bit_cycles", en_cnt[i], DIM);
      end
      if (bus.done) last_done = c;
      if (rn) begin
         if (ph == 0 && st) begin
            t_load = c + 1;
            t_last = -1;
            rows   = 0;
`ifdef SYSTOLIC_SEQ_ACCUM_EN
            accum_m = ac;
`else
            accum_m = ac & 1'b0;
`endif
            for (int i = 0; i < DIM; i++) en_cnt[i] = 0;
         end else if (ph == 1 && rv) begin
            if (rows == DIM - 1) t_last = c;
            rows++;
         end
      end
      c++;
   endtask

   initial begin
      int t0;
      int d0;
      int gap;
      bit rv;
      bit st;
      rst_n       = 1'b0;
      bus.start   = 1'b0;
      bus.row_vld = 1'b0;
`ifdef SYSTOLIC_SEQ_ACCUM_EN
      bus.accum   = 1'b0;
`endif
      // reset, then idle with row_vld toggling
      for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'($urandom % 2), 1'b0);
      for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, 1'(i % 2), 1'b0);

      // back-to-back rows
      cycle(1'b1, 1'b1, 1'b0, 1'b0);
      t0 = cur; d0 = last_done;
      for (int k = 0; k < 60 && last_done == d0; k++) cycle(1'b1, 1'b0, 1'b1, 1'b0);
      chk("done_latency", last_done - t0, 31);
      cycle(1'b1, 1'b0, 1'b0, 1'b0);

      // three-cycle stall after row 4
      cycle(1'b1, 1'b1, 1'b0, 1'b0);
      t0 = cur; d0 = last_done; gap = 0;
      for (int k = 0; k < 60 && last_done == d0; k++) begin
         rv = 1'b1;
         if (rows == 5 && gap < 3) begin
            rv = 1'b0;
            gap++;
         end
         cycle(1'b1, 1'b0, rv, 1'b0);
      end
      chk("done_latency_stall", last_done - t0, 34);

      // start during EXEC and DONE is ignored; start right after DONE works
      cycle(1'b1, 1'b1, 1'b0, 1'b0);
      t0 = cur; d0 = last_done;
      for (int k = 0; k < 60 && last_done == d0; k++) begin
         st = (phase(c) == 2 && (c - t_last - 1) == 5) || phase(c) == 3;
         cycle(1'b1, st, 1'b1, 1'b0);
      end
      chk("done_latency_spam", last_done - t0, 31);
      cycle(1'b1, 1'b1, 1'b0, 1'b0);
      cycle(1'b1, 1'b0, 1'b0, 1'b0);
      chk("restart_busy", 32'(bus.busy), 32'd1);
      d0 = last_done;
      for (int k = 0; k < 120 && last_done == d0; k++) cycle(1'b1, 1'b0, 1'($urandom % 2), 1'b0);
      chk("restart_done_seen", 32'(last_done != d0), 32'd1);

      // random traffic
      for (int k = 0; k < 400; k++)
         cycle(1'b1, 1'(($urandom % 6) == 0), 1'($urandom % 2), 1'($urandom % 2));

      // asynchronous reset in the middle of EXEC
      for (int k = 0; k < 60 && phase(c) != 0; k++) cycle(1'b1, 1'b0, 1'b1, 1'b0);
      cycle(1'b1, 1'b1, 1'b0, 1'b0);
      for (int k = 0; k < 60 && !(phase(c) == 2 && (c - t_last - 1) == 10); k++)
         cycle(1'b1, 1'b0, 1'b1, 1'b0);
      chk("reached_exec10", 32'(phase(c) == 2 && (c - t_last - 1) == 10), 32'd1);
      for (int k = 0; k < 3; k++) cycle(1'b0, 1'b0, 1'b1, 1'b0);
      cycle(1'b1, 1'b0, 1'b0, 1'b0);

      // clean run after reset, requesting accumulate
      cycle(1'b1, 1'b1, 1'b0, 1'b1);
      t0 = cur; d0 = last_done;
      for (int k = 0; k < 60 && last_done == d0; k++) cycle(1'b1, 1'b0, 1'b1, 1'b0);
      chk("done_latency_post_reset", last_done - t0, 31);
      cycle(1'b1, 1'b0, 1'b0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
